// File: rtl/arm_dmem_ws.sv
// Wait-state data memory for the ARM-subset cores: valid/ready request port,
// fixed-latency one-cycle response, word and byte access with fault reporting.
module arm_dmem_ws #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              we,
    input  logic              byte_acc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam int LANES = DATA_W / 8;
    localparam int OFFS  = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * LANES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Handshake: a request is taken on any rising edge where req_valid and
    // req_ready are both high; the master holds req_valid and its fields
    // stable until then. resp_valid is a one-cycle pulse, no back-pressure.

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              we_q;
    logic              byte_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              go_resp;
    logic              cur_we;
    logic              cur_byte;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [IDX_W-1:0]  idx;
    logic [OFFS-1:0]   lane;
    logic              fault;
    logic [DATA_W-1:0] word_rd;
    logic [7:0]        byte_rd;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] wr_word;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid & req_ready;
    assign dbg_state = state;

    // With no wait states the access runs on the accept edge itself, so the
    // live request fields are used instead of the not-yet-latched copies.
    always_comb begin
        cur_we    = we_q;
        cur_byte  = byte_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state == S_IDLE) begin
            cur_we    = we;
            cur_byte  = byte_acc;
            cur_addr  = addr;
            cur_wdata = wdata;
        end
    end

    assign go_resp = ((state == S_IDLE) && accept && (WAIT == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd1));

    assign idx     = cur_addr[OFFS+IDX_W-1:OFFS];
    assign lane    = cur_addr[OFFS-1:0];
    assign fault   = (cur_addr >= LIMIT) || (!cur_byte && (lane != '0));
    assign word_rd = mem[idx];

    always_comb begin
        byte_rd = '0;
        wr_word = cur_byte ? word_rd : cur_wdata;
        for (int l = 0; l < LANES; l++) begin
            if (lane == OFFS'(l)) begin
                byte_rd = word_rd[l*8 +: 8];
                if (cur_byte) begin
                    wr_word[l*8 +: 8] = cur_wdata[7:0];
                end
            end
        end
    end

    assign ld_data = cur_byte ? {{(DATA_W-8){1'b0}}, byte_rd} : word_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= we;
                        byte_q  <= byte_acc;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= 4'(WAIT);
                        state   <= (WAIT == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (go_resp) begin
                resp_valid <= 1'b1;
                err        <= fault;
                rdata      <= (fault || cur_we) ? '0 : ld_data;
            end
        end
    end

    // Storage is not reset; a store commits only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (go_resp && cur_we && !fault && !reset) begin
            mem[idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_arm_dmem_ws.sv
// Directed bench for arm_dmem_ws: a WAIT=2 instance driven from a vector
// table plus hand sequences, and a WAIT=0 instance for back-to-back timing.
module tb_arm_dmem_ws;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        we         [2];
    logic        byte_acc   [2];
    logic [31:0] addr       [2];
    logic [31:0] wdata      [2];
    logic        resp_valid [2];
    logic [31:0] rdata      [2];
    logic        err        [2];
    logic [1:0]  dbg_state  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arm_dmem_ws #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT(2)) dut_w2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .we(we[0]), .byte_acc(byte_acc[0]), .addr(addr[0]), .wdata(wdata[0]),
        .resp_valid(resp_valid[0]), .rdata(rdata[0]), .err(err[0]),
        .dbg_state(dbg_state[0])
    );

    arm_dmem_ws #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT(0)) dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .we(we[1]), .byte_acc(byte_acc[1]), .addr(addr[1]), .wdata(wdata[1]),
        .resp_valid(resp_valid[1]), .rdata(rdata[1]), .err(err[1]),
        .dbg_state(dbg_state[1])
    );

    typedef struct {
        logic        we;
        logic        bt;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        chk_rd;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete transaction; lat counts negedges after the accept edge
    // up to the response, busy counts those with req_ready low.
    task automatic access(input int sel, input logic w, input logic b,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e,
                          output int lat, output int busy,
                          output logic post_resp, output logic post_ready);
        int n;
        @(negedge clk);
        req_valid[sel] = 1'b1;
        we[sel]        = w;
        byte_acc[sel]  = b;
        addr[sel]      = a;
        wdata[sel]     = d;
        n = 0;
        while (!req_ready[sel] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid[sel] = 1'b0;
        lat  = 0;
        busy = 0;
        rd   = '0;
        e    = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (!req_ready[sel]) busy++;
            if (resp_valid[sel]) begin
                rd = rdata[sel];
                e  = err[sel];
                break;
            end
        end
        @(negedge clk);
        post_resp  = resp_valid[sel];
        post_ready = req_ready[sel];
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        logic        pr;
        logic        prdy;
        logic        saw;
        int          lat;
        int          busy;

        vecs[0]  = '{1'b1, 1'b0, 32'h08,  32'h00000077, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h20,  32'h11223344, 32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h22,  32'hFFFFFFAA, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h20,  32'h0,        32'h11AA3344, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h23,  32'h0,        32'h00000011, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h21,  32'h0,        32'h0,        1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h24,  32'h12345678, 32'h0,        1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h25,  32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h24,  32'h0,        32'h12345678, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 32'hFC,  32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'hFC,  32'h0,        32'hCAFEF00D, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 32'h13,  32'h0,        32'h000000DE, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 32'h101, 32'h00000055, 32'h0,        1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 32'h11,  32'h00000055, 32'h0,        1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 32'h102, 32'h0,        32'h0,        1'b1, 1'b1};

        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            we[s]        = 1'b0;
            byte_acc[s]  = 1'b0;
            addr[s]      = '0;
            wdata[s]     = '0;
        end

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ready",  32'(req_ready[0]),  32'd1);
        chk("reset_resp",   32'(resp_valid[0]), 32'd0);
        chk("reset_rdata",  rdata[0],           32'd0);
        chk("reset_err",    32'(err[0]),        32'd0);
        chk("reset_ready0", 32'(req_ready[1]),  32'd1);
        reset = 1'b0;

        // Vector table on the WAIT=2 instance
        for (int i = 0; i < 19; i++) begin
            access(0, vecs[i].we, vecs[i].bt, vecs[i].a, vecs[i].d, rd, e, lat, busy, pr, prdy);
            chk($sformatf("v%0d_latency", i), 32'(lat),  32'd3);
            chk($sformatf("v%0d_busy", i),    32'(busy), 32'd3);
            chk($sformatf("v%0d_err", i),     32'(e),    32'(vecs[i].exp_err));
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_pulse", i),   32'(pr),   32'd0);
            chk($sformatf("v%0d_ready", i),   32'(prdy), 32'd1);
        end

        // Reset one cycle after accepting a store: store dropped, no response
        @(negedge clk);
        req_valid[0] = 1'b1;
        we[0]        = 1'b1;
        byte_acc[0]  = 1'b0;
        addr[0]      = 32'h08;
        wdata[0]     = 32'h00000005;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        saw   = 1'b0;
        #1;
        chk("midrst_ready_now", 32'(req_ready[0]), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid[0]) saw = 1'b1;
        end
        chk("midrst_rdata", rdata[0], 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid[0]) saw = 1'b1;
        end
        chk("midrst_no_resp", 32'(saw), 32'd0);
        chk("midrst_ready",   32'(req_ready[0]), 32'd1);
        access(0, 1'b0, 1'b0, 32'h08, 32'h0, rd, e, lat, busy, pr, prdy);
        chk("midrst_readback", rd, 32'h00000077);
        chk("midrst_rb_lat",   32'(lat), 32'd3);

        // WAIT=0: request held high, accepted every second edge
        @(negedge clk);
        req_valid[1] = 1'b1;
        we[1]        = 1'b1;
        byte_acc[1]  = 1'b0;
        addr[1]      = 32'h40;
        wdata[1]     = 32'h0BADCAFE;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("w0_c%0d_ready", c), 32'(req_ready[1]),  32'(c % 2 == 0));
            chk($sformatf("w0_c%0d_resp", c),  32'(resp_valid[1]), 32'(c % 2 == 1));
            @(negedge clk);
        end
        req_valid[1] = 1'b0;

        access(1, 1'b0, 1'b0, 32'h40, 32'h0, rd, e, lat, busy, pr, prdy);
        chk("w0_ld_lat",   32'(lat),  32'd1);
        chk("w0_ld_busy",  32'(busy), 32'd1);
        chk("w0_ld_rdata", rd,        32'h0BADCAFE);
        chk("w0_ld_pulse", 32'(pr),   32'd0);
        access(1, 1'b0, 1'b1, 32'h41, 32'h0, rd, e, lat, busy, pr, prdy);
        chk("w0_ldb_rdata", rd, 32'h000000CA);
        access(1, 1'b0, 1'b0, 32'h42, 32'h0, rd, e, lat, busy, pr, prdy);
        chk("w0_mis_err",   32'(e), 32'd1);
        chk("w0_mis_rdata", rd,     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
